// File: rtl/imem_prog_if.sv
// imem_prog_if -- fetch and programming bus of the instruction memory.
//
// Parameters DEPTH / INSTR_W / AW must match those of imem_prog.
// Optional macro IMEM_PARITY_EN adds fetch_perr.
//
// Signals
//   fetch_req/fetch_addr   -> fetch request and byte address
//   fetch_ready            <- fetch accepted this cycle (with fetch_req)
//   fetch_valid/instr/oob/misalign(/perr) <- fetch result, one cycle later
//   load_start/load_base   -> start a programming burst at a word index
//   load_valid/data/last   -> burst beat stream
//   load_ready             <- beat accepted this cycle (with load_valid)
//   load_busy/full/count   <- programming status
//
// Handshake: a transfer happens in exactly the cycle where the producer's
// request/valid and the consumer's ready are both high at the rising edge;
// ready may depend combinationally on the producer's inputs, never the other
// way round, and the producer holds its payload while waiting.
interface imem_prog_if #(
   parameter int DEPTH   = 256,
   parameter int INSTR_W = 32,
   parameter int AW      = 64
);
   localparam int LW = $clog2(DEPTH);

   logic               fetch_req;
   logic [AW-1:0]      fetch_addr;
   logic               fetch_ready;
   logic               fetch_valid;
   logic [INSTR_W-1:0] fetch_instr;
   logic               fetch_oob;
   logic               fetch_misalign;
`ifdef IMEM_PARITY_EN
   logic               fetch_perr;
`endif
   logic               load_start;
   logic [LW-1:0]      load_base;
   logic               load_valid;
   logic [INSTR_W-1:0] load_data;
   logic               load_last;
   logic               load_ready;
   logic               load_busy;
   logic               load_full;
   logic [LW:0]        load_count;

   modport master (
`ifdef IMEM_PARITY_EN
      input  fetch_perr,
`endif
      output fetch_req, fetch_addr, load_start, load_base,
             load_valid, load_data, load_last,
      input  fetch_ready, fetch_valid, fetch_instr, fetch_oob, fetch_misalign,
             load_ready, load_busy, load_full, load_count
   );

   modport slave (
`ifdef IMEM_PARITY_EN
      output fetch_perr,
`endif
      input  fetch_req, fetch_addr, load_start, load_base,
             load_valid, load_data, load_last,
      output fetch_ready, fetch_valid, fetch_instr, fetch_oob, fetch_misalign,
             load_ready, load_busy, load_full, load_count
   );
endinterface

// File: rtl/imem_prog.sv
// imem_prog -- programmable instruction memory.
//
// A DEPTH x INSTR_W word array read by single-cycle-latency fetches and
// written by programming bursts. The IDLE/LOAD FSM is visible as load_busy.
// Memory contents are not reset; a reset only aborts a burst in progress.
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    imem_prog_if.slave (fetch and load signals)
//
// Optional macro IMEM_PARITY_EN: stores one even-parity bit per word and
// drives bus.fetch_perr, registered alongside the fetch result.
module imem_prog #(
   parameter int DEPTH   = 256,
   parameter int INSTR_W = 32,
   parameter int AW      = 64
) (
   input  logic       clk,
   input  logic       reset,
   imem_prog_if.slave bus
);
   localparam int LW = $clog2(DEPTH);
   localparam logic [INSTR_W-1:0] NOP = INSTR_W'(32'h0000_0013);

   typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

   state_t             state_q;
   logic [LW-1:0]      ptr_q;
   logic [LW:0]        load_count_q;
   logic               load_full_q;
   logic               fetch_valid_q;
   logic               fetch_oob_q;
   logic               fetch_misalign_q;
   logic [INSTR_W-1:0] fetch_instr_q;
   logic [INSTR_W-1:0] mem_q [DEPTH];

   logic               fetch_fire;
   logic               load_fire;
   logic               ptr_at_end;
   logic [LW-1:0]      fetch_idx;
   logic               fetch_oob_d;
   logic [INSTR_W-1:0] fetch_instr_d;

   // load_start wins over a same-cycle fetch so the burst can start at once.
   assign bus.fetch_ready = (state_q == IDLE) && !bus.load_start;
   assign fetch_fire      = bus.fetch_req && bus.fetch_ready;
   assign bus.load_ready  = (state_q == LOAD);
   assign load_fire       = bus.load_valid && (state_q == LOAD);
   assign ptr_at_end      = (ptr_q == LW'(DEPTH - 1));

   // Any set bit above the index field is out of range; no aliasing.
   assign fetch_idx     = bus.fetch_addr[LW+1:2];
   assign fetch_oob_d   = |bus.fetch_addr[AW-1:LW+2];
   assign fetch_instr_d = fetch_oob_d ? NOP : mem_q[fetch_idx];

   // Storage has no reset so a program survives a reset.
   always_ff @(posedge clk) begin
      if (load_fire) mem_q[ptr_q] <= bus.load_data;
   end

`ifdef IMEM_PARITY_EN
   logic par_q [DEPTH];
   logic fetch_perr_q;
   logic fetch_perr_d;

   // Even parity: stored bit makes the word plus parity XOR to zero.
   assign fetch_perr_d = !fetch_oob_d && ((^mem_q[fetch_idx]) != par_q[fetch_idx]);
   assign bus.fetch_perr = fetch_perr_q;

   always_ff @(posedge clk) begin
      if (load_fire) par_q[ptr_q] <= ^bus.load_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)           fetch_perr_q <= 1'b0;
      else if (fetch_fire) fetch_perr_q <= fetch_perr_d;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         ptr_q            <= '0;
         load_count_q     <= '0;
         load_full_q      <= 1'b0;
         fetch_valid_q    <= 1'b0;
         fetch_instr_q    <= '0;
         fetch_oob_q      <= 1'b0;
         fetch_misalign_q <= 1'b0;
      end else begin
         fetch_valid_q <= fetch_fire;
         // Result fields only change on an accepted fetch, otherwise hold.
         if (fetch_fire) begin
            fetch_instr_q    <= fetch_instr_d;
            fetch_oob_q      <= fetch_oob_d;
            fetch_misalign_q <= |bus.fetch_addr[1:0];
         end
         case (state_q)
            IDLE: begin
               if (bus.load_start) begin
                  state_q      <= LOAD;
                  ptr_q        <= bus.load_base;
                  load_count_q <= '0;
                  load_full_q  <= 1'b0;
               end
            end
            LOAD: begin
               if (bus.load_valid) begin
                  load_count_q <= load_count_q + (LW+1)'(1);
                  // The last index ends the burst; the pointer never wraps.
                  if (bus.load_last || ptr_at_end) begin
                     state_q <= IDLE;
                     if (ptr_at_end) load_full_q <= 1'b1;
                  end else begin
                     ptr_q <= ptr_q + LW'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.load_busy      = (state_q == LOAD);
   assign bus.load_full      = load_full_q;
   assign bus.load_count     = load_count_q;
   assign bus.fetch_valid    = fetch_valid_q;
   assign bus.fetch_instr    = fetch_instr_q;
   assign bus.fetch_oob      = fetch_oob_q;
   assign bus.fetch_misalign = fetch_misalign_q;
endmodule

// File: tb/tb_imem_prog.sv
// tb_imem_prog -- self-checking bench for imem_prog (DEPTH=256, 32-bit words,
// 64-bit addresses). Define IMEM_PARITY_EN to also exercise fetch_perr.
module tb_imem_prog;
   localparam int DEPTH = 256;
   localparam int LW    = 8;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   imem_prog_if #(.DEPTH(DEPTH), .INSTR_W(32), .AW(64)) bus ();

   imem_prog #(.DEPTH(DEPTH), .INSTR_W(32), .AW(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // ---------------- reference model ----------------
   logic [31:0] model_mem [DEPTH];
   bit          written   [DEPTH];
   int          wlist[$];
   logic [31:0] exp_q[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Word index is the byte address divided by four; beyond DEPTH words the
   // memory answers with a NOP.
   function automatic logic [31:0] model_word(input logic [63:0] addr);
      if ((addr >> 2) >= 64'(DEPTH)) return 32'h0000_0013;
      return model_mem[int'(addr >> 2)];
   endfunction

   function automatic bit model_oob(input logic [63:0] addr);
      return (addr >> 2) >= 64'(DEPTH);
   endfunction

   function automatic bit model_mis(input logic [63:0] addr);
      return (addr % 4) != 0;
   endfunction

   task automatic model_write(input int idx, input logic [31:0] data);
      model_mem[idx] = data;
      if (!written[idx]) begin
         written[idx] = 1'b1;
         wlist.push_back(idx);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one burst. Beats arriving after the burst ended must see
   // load_ready low and are dropped. gaps=1 inserts random idle cycles.
   task automatic do_load(input int base, input logic [31:0] beats[$], input bit with_last,
                          input bit gaps);
      int ptr;
      int cnt;
      bit busy;
      bit full;
      ptr = base; cnt = 0; busy = 1'b1; full = 1'b0;
      bus.load_start = 1'b1;
      bus.load_base  = base[LW-1:0];
      #1;
      chk("fetch_ready_during_start", bus.fetch_ready, 0);
      step();
      bus.load_start = 1'b0;
      chk("load_busy_after_start", bus.load_busy, 1);
      for (int i = 0; i < beats.size(); i++) begin
         while (gaps && $urandom_range(0, 3) == 0) begin
            bus.load_valid = 1'b0;
            step();
         end
         bus.load_valid = 1'b1;
         bus.load_data  = beats[i];
         bus.load_last  = with_last && (i == beats.size() - 1);
         #1;
         chk("load_ready", bus.load_ready, 64'(busy));
         if (busy) begin
            model_write(ptr, beats[i]);
            cnt++;
            if (bus.load_last || ptr == DEPTH - 1) begin
               busy = 1'b0;
               if (ptr == DEPTH - 1) full = 1'b1;
            end else begin
               ptr++;
            end
         end
         step();
      end
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      chk("load_busy_end",  bus.load_busy,  64'(busy));
      chk("load_count_end", bus.load_count, 64'(cnt));
      chk("load_full_end",  bus.load_full,  64'(full));
   endtask

   task automatic do_fetch(input string nm, input logic [63:0] addr, input logic [31:0] ei,
                           input bit eo, input bit em);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = addr;
      #1;
      chk({nm, "_ready"}, bus.fetch_ready, 1);
      step();
      bus.fetch_req = 1'b0;
      chk({nm, "_valid"},    bus.fetch_valid,    1);
      chk({nm, "_instr"},    bus.fetch_instr,    64'(ei));
      chk({nm, "_oob"},      bus.fetch_oob,      64'(eo));
      chk({nm, "_misalign"}, bus.fetch_misalign, 64'(em));
`ifdef IMEM_PARITY_EN
      chk({nm, "_perr"},     bus.fetch_perr,     0);
`endif
   endtask

   // ---------------- stimulus tables ----------------
   typedef struct {
      string       nm;
      logic [63:0] addr;
      logic [31:0] exp_instr;
      bit          exp_oob;
      bit          exp_mis;
   } fvec_t;

   fvec_t vecs[8];

   initial begin
      logic [31:0] beats[$];
      logic [31:0] last_word;
      logic [31:0] d0;

      vecs[0] = '{"f_w0",      64'h0,                   32'h0050_0093, 1'b0, 1'b0};
      vecs[1] = '{"f_w1",      64'h4,                   32'h00a0_0113, 1'b0, 1'b0};
      vecs[2] = '{"f_w2",      64'h8,                   32'h0020_81b3, 1'b0, 1'b0};
      vecs[3] = '{"f_mis6",    64'h6,                   32'h00a0_0113, 1'b0, 1'b1};
      vecs[4] = '{"f_oob400",  64'h400,                 32'h0000_0013, 1'b1, 1'b0};
      vecs[5] = '{"f_oob401",  64'h401,                 32'h0000_0013, 1'b1, 1'b1};
      vecs[6] = '{"f_alias",   64'h8000_0000_0000_0008, 32'h0000_0013, 1'b1, 1'b0};
      vecs[7] = '{"f_mis9",    64'h9,                   32'h0020_81b3, 1'b0, 1'b1};

      bus.fetch_req  = 1'b0;
      bus.fetch_addr = '0;
      bus.load_start = 1'b0;
      bus.load_base  = '0;
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      bus.load_last  = 1'b0;
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_fetch_valid",    bus.fetch_valid,    0);
      chk("rst_fetch_instr",    bus.fetch_instr,    0);
      chk("rst_fetch_oob",      bus.fetch_oob,      0);
      chk("rst_fetch_misalign", bus.fetch_misalign, 0);
      chk("rst_load_full",      bus.load_full,      0);
      chk("rst_load_count",     bus.load_count,     0);
      chk("rst_load_busy",      bus.load_busy,      0);
      reset = 1'b0;
      step();
      chk("idle_fetch_ready",   bus.fetch_ready,    1);

      // Three-instruction program at word 0.
      beats = '{32'h0050_0093, 32'h00a0_0113, 32'h0020_81b3};
      do_load(0, beats, 1'b1, 1'b0);

      for (int i = 0; i < 8; i++)
         do_fetch(vecs[i].nm, vecs[i].addr, vecs[i].exp_instr, vecs[i].exp_oob, vecs[i].exp_mis);

      // Back-to-back fetches: one result per cycle, in order.
      exp_q = '{32'h0050_0093, 32'h00a0_0113, 32'h0020_81b3};
      bus.fetch_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.fetch_addr = 64'(i * 4);
         step();
         last_word = exp_q.pop_front();
         chk("b2b_valid", bus.fetch_valid, 1);
         chk("b2b_instr", bus.fetch_instr, 64'(last_word));
      end
      bus.fetch_req = 1'b0;
      step();
      chk("hold_valid", bus.fetch_valid, 0);
      chk("hold_instr", bus.fetch_instr, 64'(last_word));

      // Burst at 254 without load_last stops at the last index.
      beats = '{32'hdead_0001, 32'hdead_0002, 32'hdead_0003, 32'hdead_0004};
      do_load(254, beats, 1'b0, 1'b0);
      do_fetch("f_top", 64'h3fc, model_word(64'h3fc), 1'b0, 1'b0);
      do_fetch("f_wrap0", 64'h0, model_word(64'h0), 1'b0, 1'b0);

      // load_start beats a same-cycle fetch, then reset aborts the burst.
      d0 = $urandom;
      bus.load_start = 1'b1;
      bus.load_base  = 8'd10;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 64'h28;
      #1;
      chk("prio_fetch_ready", bus.fetch_ready, 0);
      step();
      bus.load_start = 1'b0;
      bus.fetch_req  = 1'b0;
      chk("prio_load_busy",   bus.load_busy,   1);
      chk("prio_fetch_valid", bus.fetch_valid, 0);
      bus.load_valid = 1'b1;
      bus.load_data  = d0;
      step();
      model_write(10, d0);
      bus.load_valid = 1'b0;
      chk("abort_count_pre", bus.load_count, 1);
      #2 reset = 1'b1;
      #1;
      chk("abort_busy",  bus.load_busy,   0);
      chk("abort_count", bus.load_count,  0);
      chk("abort_instr", bus.fetch_instr, 0);
      step();
      #1 reset = 1'b0;
      step();
      do_fetch("abort_word", 64'h28, d0, 1'b0, 1'b0);

      // Randomised mix of bursts and fetches against the model.
      for (int it = 0; it < 40; it++) begin
         int kind;
         kind = $urandom_range(0, 9);
         beats = {};
         if (kind < 3) begin
            int n;
            n = $urandom_range(1, 8);
            for (int b = 0; b < n; b++) beats.push_back($urandom);
            do_load($urandom_range(0, DEPTH - 1), beats, 1'b1, 1'b1);
         end else if (kind == 3) begin
            int k;
            k = $urandom_range(1, 4);
            for (int b = 0; b < k + int'($urandom_range(0, 2)); b++) beats.push_back($urandom);
            do_load(DEPTH - k, beats, 1'b0, 1'b1);
         end else begin
            for (int f = 0; f < 5; f++) begin
               logic [63:0] a;
               if ($urandom_range(0, 4) == 0) begin
                  a = {$urandom, $urandom};
                  a[63:LW+2] = a[63:LW+2] | 54'h1;
               end else begin
                  a = 64'(wlist[$urandom_range(0, wlist.size() - 1)]) * 4
                      + 64'($urandom_range(0, 3));
               end
               do_fetch("rnd", a, model_word(a), model_oob(a), model_mis(a));
            end
         end
      end

`ifdef IMEM_PARITY_EN
      dut.par_q[1] = ~dut.par_q[1];
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 64'h4;
      step();
      bus.fetch_req = 1'b0;
      chk("perr_valid", bus.fetch_valid, 1);
      chk("perr_flag",  bus.fetch_perr,  1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
